// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants for the BCD up/down counter.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package bcd_updown_counter_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int SEG_W       = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
    localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
    localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
    localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
    localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
    localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
    localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

    function automatic logic [BCD_DIGIT_W-1:0] clamp_digit(
        input logic [BCD_DIGIT_W-1:0] d
    );
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_seg7_dec.sv
// BCD digit to active-low 7-segment decoder.
// Non-BCD codes blank the digit.
module seg7_dec
    import bcd_updown_counter_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] bcd,
    output logic [SEG_W-1:0]       seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with prescaler, sync load,
// wrap/saturate terminal mode and 7-segment outputs.
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int DIV      = 50_000_000,
    parameter int SATURATE = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    dir,
    input  logic                    load,
    input  logic [4*DIGITS-1:0]     load_val,
    output logic                    tick,
    output logic [4*DIGITS-1:0]     count,
    output logic                    rco,
    output logic                    at_term,
    output logic [7*DIGITS-1:0]     hex
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = BCD_DIGIT_W * DIGITS;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

    logic [PW-1:0] pcnt;
    logic [PW-1:0] pcnt_nxt;
    logic [CW-1:0] count_nxt;
    logic [CW-1:0] stepped;
    logic [CW-1:0] clamped;
    logic          rco_nxt;
    logic          all9;
    logic          all0;

    always_comb begin
        pcnt_nxt = pcnt + 1'b1;
        if (clr || load || pcnt == PMAX)
            pcnt_nxt = '0;
    end

    // tick is registered so it is high exactly while pcnt sits at DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            tick <= 1'b0;
        end else begin
            pcnt <= pcnt_nxt;
            tick <= (pcnt_nxt == PMAX);
        end
    end

    // Ripple chain: a digit moves only when every lower digit is at its limit
    always_comb begin
        logic run9;
        logic run0;
        logic [BCD_DIGIT_W-1:0] d;
        run9    = 1'b1;
        run0    = 1'b1;
        stepped = count;
        clamped = '0;
        for (int k = 0; k < DIGITS; k++) begin
            d = count[4*k +: 4];
            clamped[4*k +: 4] = clamp_digit(load_val[4*k +: 4]);
            if (dir && run9)
                stepped[4*k +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
            else if (!dir && run0)
                stepped[4*k +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
            run9 = run9 & (d == 4'd9);
            run0 = run0 & (d == 4'd0);
        end
        all9 = run9;
        all0 = run0;
    end

    assign at_term = dir ? all9 : all0;

    always_comb begin
        count_nxt = count;
        rco_nxt   = 1'b0;
        if (clr) begin
            count_nxt = '0;
        end else if (load) begin
            count_nxt = clamped;
        end else if (tick && en) begin
            if (!(at_term && SATURATE != 0)) begin
                count_nxt = stepped;
                rco_nxt   = at_term;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            rco   <= 1'b0;
        end else begin
            count <= count_nxt;
            rco   <= rco_nxt;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        seg7_dec u_dec (
            .bcd (count[4*g +: 4]),
            .seg (hex[7*g +: 7])
        );
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed checks of the BCD counter in wrap, saturate and
// wide/fast configurations sharing one clock and control set.
module tb_bcd_updown_counter;
    import bcd_updown_counter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        en = 1'b0;
    logic        dir = 1'b1;
    logic        load = 1'b0;
    logic [7:0]  lv2 = '0;
    logic [15:0] lv4 = '0;

    logic        tick_a, rco_a, term_a;
    logic [7:0]  cnt_a;
    logic [13:0] hex_a;
    logic        tick_s, rco_s, term_s;
    logic [7:0]  cnt_s;
    logic [13:0] hex_s;
    logic        tick_w, rco_w, term_w;
    logic [15:0] cnt_w;
    logic [27:0] hex_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_updown_counter #(.DIGITS(2), .DIV(4), .SATURATE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .dir(dir),
        .load(load), .load_val(lv2), .tick(tick_a), .count(cnt_a),
        .rco(rco_a), .at_term(term_a), .hex(hex_a)
    );

    bcd_updown_counter #(.DIGITS(2), .DIV(4), .SATURATE(1)) u_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .dir(dir),
        .load(load), .load_val(lv2), .tick(tick_s), .count(cnt_s),
        .rco(rco_s), .at_term(term_s), .hex(hex_s)
    );

    bcd_updown_counter #(.DIGITS(4), .DIV(1), .SATURATE(0)) u_w (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .dir(dir),
        .load(load), .load_val(lv4), .tick(tick_w), .count(cnt_w),
        .rco(rco_w), .at_term(term_w), .hex(hex_w)
    );

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load2(input logic [7:0] v);
        lv2  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic do_load4(input logic [15:0] v);
        lv4  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        nclk(1);
        checks++;
        if (cnt_a !== 8'h00) begin
            errors++;
            $display("FAIL reset_count: got %h exp 00", cnt_a);
        end
        checks++;
        if (rco_a !== 1'b0 || tick_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: rco %b tick %b exp 0 0", rco_a, tick_a);
        end
        checks++;
        if (hex_a !== {SEG_0, SEG_0}) begin
            errors++;
            $display("FAIL reset_hex: got %b exp %b", hex_a, {SEG_0, SEG_0});
        end
        checks++;
        if (cnt_w !== 16'h0000 || hex_w !== {4{SEG_0}}) begin
            errors++;
            $display("FAIL reset_wide: count %h hex %b", cnt_w, hex_w);
        end
        nclk(1);
        rst_n = 1'b1;
        nclk(1);
    endtask

    task automatic test_reset_midcount;
        en  = 1'b1;
        dir = 1'b1;
        do_load2(8'h37);
        nclk(6);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cnt_a !== 8'h00 || rco_a !== 1'b0 || tick_a !== 1'b0) begin
            errors++;
            $display("FAIL midreset_state: count %h rco %b tick %b exp 00 0 0",
                     cnt_a, rco_a, tick_a);
        end
        checks++;
        if (hex_a !== {SEG_0, SEG_0}) begin
            errors++;
            $display("FAIL midreset_hex: got %b exp %b", hex_a, {SEG_0, SEG_0});
        end
        nclk(1);
        rst_n = 1'b1;
        nclk(1);
    endtask

    task automatic test_up_wrap;
        en  = 1'b1;
        dir = 1'b1;
        do_load2(8'h98);
        checks++;
        if (cnt_a !== 8'h98 || hex_a !== {SEG_9, SEG_8}) begin
            errors++;
            $display("FAIL up_load: count %h hex %b exp 98", cnt_a, hex_a);
        end
        nclk(3);
        checks++;
        if (tick_a !== 1'b1 || cnt_a !== 8'h98) begin
            errors++;
            $display("FAIL up_tick1: tick %b count %h exp 1 98", tick_a, cnt_a);
        end
        nclk(1);
        checks++;
        if (cnt_a !== 8'h99 || tick_a !== 1'b0 || term_a !== 1'b1) begin
            errors++;
            $display("FAIL up_99: count %h tick %b term %b exp 99 0 1",
                     cnt_a, tick_a, term_a);
        end
        nclk(3);
        checks++;
        if (tick_a !== 1'b1 || rco_a !== 1'b0) begin
            errors++;
            $display("FAIL up_tick2: tick %b rco %b exp 1 0", tick_a, rco_a);
        end
        nclk(1);
        checks++;
        if (cnt_a !== 8'h00 || rco_a !== 1'b1) begin
            errors++;
            $display("FAIL up_wrap: count %h rco %b exp 00 1", cnt_a, rco_a);
        end
        nclk(1);
        checks++;
        if (cnt_a !== 8'h00 || rco_a !== 1'b0) begin
            errors++;
            $display("FAIL up_rco_end: count %h rco %b exp 00 0", cnt_a, rco_a);
        end
    endtask

    task automatic test_down_borrow;
        en  = 1'b1;
        dir = 1'b0;
        do_load2(8'h10);
        nclk(4);
        checks++;
        if (cnt_a !== 8'h09 || rco_a !== 1'b0) begin
            errors++;
            $display("FAIL down_09: count %h rco %b exp 09 0", cnt_a, rco_a);
        end
        nclk(4);
        checks++;
        if (cnt_a !== 8'h08) begin
            errors++;
            $display("FAIL down_08: count %h exp 08", cnt_a);
        end
        do_load2(8'h00);
        checks++;
        if (term_a !== 1'b1) begin
            errors++;
            $display("FAIL down_term: at_term %b exp 1", term_a);
        end
        nclk(4);
        checks++;
        if (cnt_a !== 8'h99 || rco_a !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap: count %h rco %b exp 99 1", cnt_a, rco_a);
        end
        nclk(1);
        checks++;
        if (rco_a !== 1'b0) begin
            errors++;
            $display("FAIL down_rco_end: rco %b exp 0", rco_a);
        end
    endtask

    task automatic test_saturate;
        int ticks;
        int bad;
        ticks = 0;
        bad   = 0;
        en    = 1'b1;
        dir   = 1'b1;
        do_load2(8'h99);
        for (int i = 0; i < 14; i++) begin
            nclk(1);
            if (tick_s === 1'b1) ticks++;
            if (cnt_s !== 8'h99 || rco_s !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sat_hold: %0d bad cycles, last count %h rco %b exp 99 0",
                     bad, cnt_s, rco_s);
        end
        checks++;
        if (ticks != 3 || term_s !== 1'b1) begin
            errors++;
            $display("FAIL sat_ticks: ticks %0d term %b exp 3 1", ticks, term_s);
        end
    endtask

    task automatic test_pause_priority;
        int ticks;
        ticks = 0;
        en    = 1'b0;
        dir   = 1'b1;
        do_load2(8'h45);
        for (int i = 0; i < 40; i++) begin
            nclk(1);
            if (tick_a === 1'b1) ticks++;
        end
        checks++;
        if (cnt_a !== 8'h45 || rco_a !== 1'b0) begin
            errors++;
            $display("FAIL pause_frozen: count %h rco %b exp 45 0", cnt_a, rco_a);
        end
        checks++;
        if (ticks != 10) begin
            errors++;
            $display("FAIL pause_ticks: got %0d exp 10", ticks);
        end
        clr  = 1'b1;
        lv2  = 8'h77;
        load = 1'b1;
        nclk(1);
        clr  = 1'b0;
        load = 1'b0;
        checks++;
        if (cnt_a !== 8'h00) begin
            errors++;
            $display("FAIL clr_over_load: count %h exp 00", cnt_a);
        end
        do_load2(8'hAF);
        checks++;
        if (cnt_a !== 8'h99) begin
            errors++;
            $display("FAIL load_clamp_af: count %h exp 99", cnt_a);
        end
        do_load2(8'h5B);
        checks++;
        if (cnt_a !== 8'h59) begin
            errors++;
            $display("FAIL load_clamp_5b: count %h exp 59", cnt_a);
        end
    endtask

    task automatic test_dir_change;
        en  = 1'b0;
        dir = 1'b1;
        do_load2(8'h99);
        #1;
        checks++;
        if (term_a !== 1'b1) begin
            errors++;
            $display("FAIL term_up99: got %b exp 1", term_a);
        end
        dir = 1'b0;
        #1;
        checks++;
        if (term_a !== 1'b0) begin
            errors++;
            $display("FAIL term_down99: got %b exp 0", term_a);
        end
        en = 1'b1;
        nclk(4);
        checks++;
        if (cnt_a !== 8'h98) begin
            errors++;
            $display("FAIL dir_step: count %h exp 98", cnt_a);
        end
    endtask

    task automatic test_wide;
        en  = 1'b1;
        dir = 1'b1;
        do_load4(16'h0999);
        checks++;
        if (cnt_w !== 16'h0999 || tick_w !== 1'b1) begin
            errors++;
            $display("FAIL wide_load: count %h tick %b exp 0999 1", cnt_w, tick_w);
        end
        nclk(1);
        checks++;
        if (cnt_w !== 16'h1000) begin
            errors++;
            $display("FAIL wide_carry: count %h exp 1000", cnt_w);
        end
        checks++;
        if (hex_w[27:21] !== SEG_1 || hex_w[6:0] !== SEG_0) begin
            errors++;
            $display("FAIL wide_hex: hex3 %b hex0 %b exp %b %b",
                     hex_w[27:21], hex_w[6:0], SEG_1, SEG_0);
        end
        do_load4(16'h9999);
        nclk(1);
        checks++;
        if (cnt_w !== 16'h0000 || rco_w !== 1'b1) begin
            errors++;
            $display("FAIL wide_wrap: count %h rco %b exp 0000 1", cnt_w, rco_w);
        end
        nclk(1);
        checks++;
        if (cnt_w !== 16'h0001 || rco_w !== 1'b0) begin
            errors++;
            $display("FAIL wide_next: count %h rco %b exp 0001 0", cnt_w, rco_w);
        end
    endtask

    initial begin
        test_reset;
        test_reset_midcount;
        test_up_wrap;
        test_down_borrow;
        test_saturate;
        test_pause_priority;
        test_dir_change;
        test_wide;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
